// File: rtl/fmul_pipe_param.sv
// Parametrised FloPoCo-format floating-point multiplier.
// Word layout: {exc[1:0], sign, exp[WE-1:0], frac[WF-1:0]}; exc 00 zero, 01 normal, 10 inf, 11 NaN.
// Pipeline of STAGES registers with valid/ready flow control and a global stall.
// Rounding is round-to-nearest-even. Subnormals are flushed to zero.
module fmul_pipe_param #(
    parameter int WE     = 5,
    parameter int WF     = 11,
    parameter int STAGES = 2,
    parameter int ID     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WE+WF+2:0]    X,
    input  logic [WE+WF+2:0]    Y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WE+WF+2:0]    R
);

    localparam int W = WE + WF + 3;
    localparam logic [WE+1:0] BIAS = (WE+2)'((1 << (WE-1)) - 1);

    // Range guard for the parameters; the instance tag has no functional effect.
    if (WE < 3 || WF < 2 || STAGES < 1 || STAGES > 4 || ID < 0) begin : g_param_range
    end

    // Data carried from the multiplier to the rounding logic.
    typedef struct packed {
        logic            sign;
        logic [1:0]      exc;   // pair result; 01 means "take from rounding"
        logic [WE+1:0]   exp;   // eX + eY - BIAS, two's complement
        logic [2*WF+1:0] prod;  // {1,fX} * {1,fY}
    } mul_t;

    // Data carried from the rounding adder to the exception combine.
    typedef struct packed {
        logic             sign;
        logic [1:0]       exc;
        logic [WE+WF+1:0] sum;  // {E, frac} after the rounding increment
    } rnd_t;

    // ------------------------------------------------------------------
    // Flow control: the whole pipe advances together or holds together.
    // ------------------------------------------------------------------
    logic stall;
    logic advance;
    logic accept;
    logic [STAGES-1:0] vld;

    assign stall     = out_valid & ~out_ready;
    assign advance   = ~stall;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;
    assign out_valid = vld[STAGES-1];

    // Valid shift chain; bubbles move through the pipe just like data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (advance) begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            vld <= STAGES'({vld, accept});
        end
    end

    // ------------------------------------------------------------------
    // Multiply: sign, exponent sum, significand product, exception pair.
    // ------------------------------------------------------------------
    logic [1:0] exc_x;
    logic [1:0] exc_y;
    logic [1:0] exc_pair;
    mul_t       mul_d;
    mul_t       mul_q;

    assign exc_x = X[W-1:W-2];
    assign exc_y = Y[W-1:W-2];

    // Exception pair table: NaN dominates, then 0*inf -> NaN, then inf, then zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        exc_pair = 2'b00;
        if (exc_x == 2'b11 || exc_y == 2'b11) begin
            exc_pair = 2'b11;
        end else begin
            case ({exc_x, exc_y})
                4'b0101:                   exc_pair = 2'b01;
                4'b0110, 4'b1001, 4'b1010: exc_pair = 2'b10;
                4'b0010, 4'b1000:          exc_pair = 2'b11;
                default:                   exc_pair = 2'b00;
            endcase
        end
    end

    // Operand fields of non-normal inputs flow through but are masked later by exc_pair.
    always_comb begin
        mul_d      = '0;
        mul_d.sign = X[W-3] ^ Y[W-3];
        mul_d.exc  = exc_pair;
        mul_d.exp  = {2'b00, X[W-4:WF]} + {2'b00, Y[W-4:WF]} - BIAS;
        mul_d.prod = {{(WF+1){1'b0}}, 1'b1, X[WF-1:0]} * {{(WF+1){1'b0}}, 1'b1, Y[WF-1:0]};
    end

    if (STAGES >= 2) begin : g_mul_reg
        // Product register after the multiplier.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mul_q <= '0;
            end else if (advance) begin
                mul_q <= mul_d;
            end
        end
    end else begin : g_mul_comb
        assign mul_q = mul_d;
    end

    // ------------------------------------------------------------------
    // Normalise and round to nearest even in one {E, frac} + rnd add.
    // ------------------------------------------------------------------
    logic          norm;
    logic [WF-1:0] frac;
    logic          guard;
    logic          sticky;
    logic          rnd;
    logic [WE+1:0] e_adj;
    rnd_t          rnd_d;
    rnd_t          rnd_q;

    // Pick the mantissa window, guard and sticky bits, then apply the increment.
    always_comb begin
        norm   = mul_q.prod[2*WF+1];
        frac   = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        if (norm) begin
            frac   = mul_q.prod[2*WF:WF+1];
            guard  = mul_q.prod[WF];
            sticky = |mul_q.prod[WF-1:0];
        end else begin
            frac   = mul_q.prod[2*WF-1:WF];
            guard  = mul_q.prod[WF-1];
            sticky = |mul_q.prod[WF-2:0];
        end
        rnd        = guard & (sticky | frac[0]);
        e_adj      = mul_q.exp + {{(WE+1){1'b0}}, norm};
        rnd_d      = '0;
        rnd_d.sign = mul_q.sign;
        rnd_d.exc  = mul_q.exc;
        // A carry out of the mantissa bumps E automatically.
        rnd_d.sum  = {e_adj, frac} + {{(WE+WF+1){1'b0}}, rnd};
    end

    if (STAGES >= 3) begin : g_rnd_reg
        // Register after the rounding adder.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rnd_q <= '0;
            end else if (advance) begin
                rnd_q <= rnd_d;
            end
        end
    end else begin : g_rnd_comb
        assign rnd_q = rnd_d;
    end

    // ------------------------------------------------------------------
    // Exception combine and canonical packing.
    // ------------------------------------------------------------------
    logic [WE+1:0] e_fin;
    logic [W-1:0]  word_d;
    logic [W-1:0]  word_q;

    // Range-check the rounded exponent; non-normal results carry zero exp/frac.
    always_comb begin
        e_fin          = rnd_q.sum[WE+WF+1:WF];
        word_d         = '0;
        word_d[W-3]    = rnd_q.sign;
        if (rnd_q.exc == 2'b01) begin
            if (e_fin[WE+1]) begin
                word_d[W-1:W-2] = 2'b00;        // negative exponent: underflow to zero
            end else if (e_fin[WE]) begin
                word_d[W-1:W-2] = 2'b10;        // exponent >= 2^WE: overflow to inf
            end else begin
                word_d[W-1:W-2] = 2'b01;
                word_d[W-4:WF]  = e_fin[WE-1:0];
                word_d[WF-1:0]  = rnd_q.sum[WF-1:0];
            end
        end else begin
            word_d[W-1:W-2] = rnd_q.exc;
        end
    end

    if (STAGES >= 4) begin : g_word_reg
        // Register after the exception combine.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q <= '0;
            end else if (advance) begin
                word_q <= word_d;
            end
        end
    end else begin : g_word_comb
        assign word_q = word_d;
    end

    // Output register: always the last pipeline stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            R <= '0;
        end else if (advance) begin
            R <= word_q;
        end
    end

endmodule

// File: tb/tb_fmul_pipe_param.sv
// Self-checking bench for fmul_pipe_param (WE=5, WF=11, STAGES=2).
// A driver pushes expected words into a scoreboard on accept; a monitor pops on each output handshake.
module tb_fmul_pipe_param;

    localparam int WE     = 5;
    localparam int WF     = 11;
    localparam int STAGES = 2;
    localparam int W      = WE + WF + 3;
    localparam int BIAS   = (1 << (WE-1)) - 1;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] R;

    fmul_pipe_param #(.WE(WE), .WF(WF), .STAGES(STAGES), .ID(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] r;
        int           cyc;
        bit           lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   stall_cnt = 0;
    bit   drv_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: exact integer product, explicit round-half-even, IEEE-like exception rules.
    function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        int           cx;
        int           cy;
        longint       one;
        longint       m;
        longint       q;
        longint       rem;
        longint       half;
        int           k;
        int           e;
        logic [W-1:0] r;
        r       = '0;
        cx      = int'(x[W-1:W-2]);
        cy      = int'(y[W-1:W-2]);
        r[W-3]  = x[W-3] ^ y[W-3];
        if (cx == 3 || cy == 3 || (cx == 0 && cy == 2) || (cx == 2 && cy == 0)) begin
            r[W-1:W-2] = 2'b11;
        end else if (cx == 2 || cy == 2) begin
            r[W-1:W-2] = 2'b10;
        end else if (cx == 0 || cy == 0) begin
            r[W-1:W-2] = 2'b00;
        end else begin
            one  = longint'(1) << WF;
            m    = (one + longint'(x[WF-1:0])) * (one + longint'(y[WF-1:0]));
            k    = (m >= (longint'(1) << (2*WF+1))) ? WF + 1 : WF;
            q    = m >> k;
            rem  = m - (q << k);
            half = longint'(1) << (k - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
            e = int'(x[W-4:WF]) + int'(y[W-4:WF]) - BIAS + (k - WF);
            if (q == (longint'(1) << (WF+1))) begin
                q = q >> 1;
                e++;
            end
            if (e < 0) begin
                r[W-1:W-2] = 2'b00;
            end else if (e >= (1 << WE)) begin
                r[W-1:W-2] = 2'b10;
            end else begin
                r[W-1:W-2] = 2'b01;
                r[W-4:WF]  = WE'(e);
                r[WF-1:0]  = WF'(q - one);
            end
        end
        return r;
    endfunction

    // Random operand; mostly normals, optionally any class, sometimes with zeroed low fraction bits.
    function automatic logic [W-1:0] rand_op(input bit any_exc);
        logic [W-1:0] v;
        int           sel;
        v   = W'($urandom);
        sel = $urandom_range(0, 15);
        if (!any_exc || sel < 12) v[W-1:W-2] = 2'b01;
        else if (sel == 12)      v[W-1:W-2] = 2'b00;
        else if (sel == 13)      v[W-1:W-2] = 2'b10;
        else if (sel == 14)      v[W-1:W-2] = 2'b11;
        if ($urandom_range(0, 1) == 1) v[W-4:WF] = WE'(BIAS - 4 + $urandom_range(0, 8));
        if ($urandom_range(0, 3) == 0) v[5:0] = '0;
        return v;
    endfunction

    // Drive one operand pair starting at posedge+1; returns at posedge+1 after it is accepted.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input bit lat,
                        input logic [W-1:0] exp_r);
        int waited;
        bit done;
        waited   = 0;
        done     = 1'b0;
        in_valid = 1'b1;
        X        = x;
        Y        = y;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{exp_r, cyc, lat});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                waited++;
                if (waited > 100) begin
                    check("send_timeout", 32'd1, 32'd0);
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", sb.size(), 0);
        repeat (STAGES + 2) @(posedge clk);
        #1;
    endtask

    // Monitor: flow-control rule, output hold under stall, ordering and latency.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 32'd1, 32'd0);
                end else begin
                    check("R", R, sb[0].r);
                    if (out_ready) begin
                        if (sb[0].lat) check("latency", cyc - sb[0].cyc, STAGES);
                        sb.delete(0);
                    end else begin
                        stall_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] dx [7] = '{19'h27C00, 19'h27801, 19'h27803, 19'h2F800, 19'h20000, 19'h00000, 19'h10000};
    logic [W-1:0] dy [7] = '{19'h27C00, 19'h27C00, 19'h27C00, 19'h28000, 19'h27000, 19'h40000, 19'h27800};
    logic [W-1:0] dr [7] = '{19'h28100, 19'h27C02, 19'h27C04, 19'h40000, 19'h00000, 19'h60000, 19'h10000};

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        X         = '0;
        Y         = '0;
        out_ready = 1'b1;
        drv_done  = 1'b0;

        // Reset state
        #12;
        check("reset_out_valid", out_valid, 0);
        check("reset_R", R, 0);
        check("reset_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);

        // Directed values, back to back, latency checked on each
        for (int i = 0; i < 7; i++) send(dx[i], dy[i], 1'b1, dr[i]);
        wait_drain();

        // Flow: 8 back-to-back ops with a 3-cycle consumer stall mid-stream
        stall_cnt = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    a = rand_op(1'b0);
                    b = rand_op(1'b0);
                    send(a, b, 1'b0, model(a, b));
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("stall_cycles", stall_cnt, 3);

        // Asynchronous reset with two ops in flight
        a = rand_op(1'b0);
        b = rand_op(1'b0);
        send(a, b, 1'b0, model(a, b));
        send(b, a, 1'b0, model(b, a));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", out_valid, 0);
        check("async_reset_R", R, 0);
        check("async_reset_in_ready", in_ready, 1);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rerelease_out_valid", out_valid, 0);
        send(19'h27C00, 19'h27C00, 1'b1, 19'h28100);
        wait_drain();

        // Randomised traffic with input gaps and random consumer back-pressure
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    a = rand_op(1'b1);
                    b = rand_op(1'b1);
                    send(a, b, 1'b0, model(a, b));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
